// File: rtl/mac_multistream_fsm_pkg.sv
// Shared types for the multi-stream MAC control FSM.
// Holds the FSM state encoding, the default stream counts and a small
// helper that classifies the states in which the engine may stall.
package mac_multistream_fsm_pkg;

  localparam int unsigned NB_SOURCE_DEF = 3;
  localparam int unsigned NB_SINK_DEF   = 1;
  localparam int unsigned NB_STREAM     = NB_SOURCE_DEF + NB_SINK_DEF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_UPDATE    = 3'd3,
    ST_WAIT      = 3'd4,
    ST_TERMINATE = 3'd5
  } mac_state_e;

  // States in which the job can make no progress without an external event
  function automatic logic is_stall_state(input mac_state_e s);
    return (s == ST_WAIT) || (s == ST_COMPUTE) || (s == ST_TERMINATE);
  endfunction

endpackage

// File: rtl/mac_multistream_fsm_addr_iter.sv
// Per-stream address generator for the multi-stream MAC controller.
// Loads the stream base address and stride when a job is accepted and
// advances the address by the stride once per completed iteration.
// The address wraps modulo 2^ADDR_WIDTH.
module mac_addr_iter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;

  // Base load at job start, stride accumulation between iterations
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else if (clear_i) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else if (load_i) begin
      addr_q   <= base_i;
      stride_q <= stride_i;
    end else if (step_i) begin
      addr_q <= addr_q + stride_q;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mac_multistream_fsm.sv
// Multi-stream MAC control FSM.
// Runs n_iter jobs of len elements back to back, starting every used
// source stream and every sink stream per iteration with per-stream
// strided base addresses, then reports completion with done/evt.
// Optional feature: define MAC_FSM_WATCHDOG_EN to add a stall watchdog
// that aborts the job with err_o; without it err_o is tied low and
// wdog_limit_i is ignored. The port list is the same in both builds.
module mac_multistream_fsm
  import mac_multistream_fsm_pkg::*;
#(
  parameter int unsigned NB_SOURCE  = 3,
  parameter int unsigned NB_SINK    = 1,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned ITER_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WDOG_WIDTH = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      clear_i,
  input  logic                                      start_i,
  input  logic [LEN_WIDTH-1:0]                      len_i,
  input  logic [ITER_WIDTH-1:0]                     n_iter_i,
  input  logic [NB_SOURCE-1:0]                      src_mask_i,
  input  logic [(NB_SOURCE+NB_SINK)*ADDR_WIDTH-1:0] base_addr_i,
  input  logic [(NB_SOURCE+NB_SINK)*ADDR_WIDTH-1:0] stride_i,
  input  logic [WDOG_WIDTH-1:0]                     wdog_limit_i,
  input  logic [NB_SOURCE-1:0]                      src_ready_start_i,
  input  logic [NB_SINK-1:0]                        snk_ready_start_i,
  output logic [NB_SOURCE-1:0]                      src_req_start_o,
  output logic [NB_SINK-1:0]                        snk_req_start_o,
  output logic [(NB_SOURCE+NB_SINK)*ADDR_WIDTH-1:0] addr_o,
  output logic                                      eng_start_o,
  output logic                                      eng_clear_o,
  output logic                                      eng_enable_o,
  input  logic [LEN_WIDTH-1:0]                      eng_cnt_i,
  input  logic                                      eng_acc_valid_i,
  output logic [ITER_WIDTH-1:0]                     iter_o,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      evt_o,
  output logic                                      err_o
);

  localparam int unsigned NSTR = NB_SOURCE + NB_SINK;

  typedef struct packed {
    logic [LEN_WIDTH-1:0]  len;
    logic [ITER_WIDTH-1:0] n_iter;
    logic [NB_SOURCE-1:0]  mask;
  } cfg_t;

  mac_state_e            state_q;
  cfg_t                  cfg_q;
  logic [ITER_WIDTH-1:0] iter_q;

  logic allrdy;
  logic eng_done;
  logic last_iter;
  logic try_launch;
  logic addr_load;
  logic addr_step;
  logic wdog_hit;

  // Unused sources count as ready so they can never block a launch
  assign allrdy     = (&(src_ready_start_i | ~cfg_q.mask)) & (&snk_ready_start_i);
  assign eng_done   = eng_acc_valid_i && (eng_cnt_i == cfg_q.len);
  assign last_iter  = (iter_q == (cfg_q.n_iter - ITER_WIDTH'(1)));
  assign try_launch = (state_q == ST_START) || (state_q == ST_WAIT) ||
                      ((state_q == ST_UPDATE) && !last_iter);
  assign addr_load  = (state_q == ST_IDLE) && start_i;
  assign addr_step  = (state_q == ST_UPDATE) && !last_iter;

  assign iter_o = iter_q;

`ifdef MAC_FSM_WATCHDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q;
  logic [WDOG_WIDTH-1:0] wdog_limit_q;
  logic [WDOG_WIDTH-1:0] wdog_inc;
  logic                  stalled;
  logic                  leaving;
  logic                  err_q;

  assign stalled  = is_stall_state(state_q);
  assign wdog_inc = wdog_q + WDOG_WIDTH'(1);
  assign wdog_hit = stalled && !eng_acc_valid_i && (wdog_limit_q != '0) &&
                    (wdog_inc == wdog_limit_q);
  // Any transition out of the current stall state restarts the count
  assign leaving  = wdog_hit ||
                    (((state_q == ST_WAIT) || (state_q == ST_TERMINATE)) && allrdy) ||
                    ((state_q == ST_COMPUTE) && eng_done);

  // Watchdog limit capture, stall counter and error pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q       <= '0;
      wdog_limit_q <= '0;
      err_q        <= 1'b0;
    end else if (clear_i) begin
      wdog_q       <= '0;
      wdog_limit_q <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= wdog_hit;
      if (addr_load) begin
        wdog_limit_q <= wdog_limit_i;
      end
      if (!stalled || leaving || eng_acc_valid_i) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_inc;
      end
    end
  end

  assign err_o = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^wdog_limit_i;
  assign wdog_hit    = 1'b0;
  assign err_o       = 1'b0;
`endif

  // Control FSM with registered stream/engine controls and status pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      cfg_q           <= '0;
      iter_q          <= '0;
      src_req_start_o <= '0;
      snk_req_start_o <= '0;
      eng_start_o     <= 1'b0;
      eng_clear_o     <= 1'b1;
      eng_enable_o    <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      evt_o           <= 1'b0;
    end else if (clear_i) begin
      state_q         <= ST_IDLE;
      cfg_q           <= '0;
      iter_q          <= '0;
      src_req_start_o <= '0;
      snk_req_start_o <= '0;
      eng_start_o     <= 1'b0;
      eng_clear_o     <= 1'b1;
      eng_enable_o    <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      evt_o           <= 1'b0;
    end else begin
      src_req_start_o <= '0;
      snk_req_start_o <= '0;
      eng_start_o     <= 1'b0;
      done_o          <= 1'b0;
      evt_o           <= 1'b0;
      if (wdog_hit) begin
        state_q      <= ST_IDLE;
        busy_o       <= 1'b0;
        eng_clear_o  <= 1'b1;
        eng_enable_o <= 1'b0;
        done_o       <= 1'b1;
        evt_o        <= 1'b1;
      end else if (try_launch) begin
        if (state_q == ST_UPDATE) begin
          iter_q <= iter_q + ITER_WIDTH'(1);
        end
        if (allrdy) begin
          src_req_start_o <= cfg_q.mask;
          snk_req_start_o <= '1;
          eng_start_o     <= 1'b1;
          eng_enable_o    <= 1'b1;
          state_q         <= ST_COMPUTE;
        end else begin
          eng_enable_o <= 1'b0;
          state_q      <= ST_WAIT;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              cfg_q        <= '{len: len_i, n_iter: n_iter_i, mask: src_mask_i};
              iter_q       <= '0;
              busy_o       <= 1'b1;
              eng_clear_o  <= 1'b0;
              eng_enable_o <= 1'b0;
              // An empty job skips the streams and only reports completion
              if ((n_iter_i == '0) || (len_i == '0)) begin
                state_q <= ST_TERMINATE;
              end else begin
                state_q <= ST_START;
              end
            end
          end
          ST_COMPUTE: begin
            if (eng_done) begin
              eng_enable_o <= 1'b0;
              state_q      <= ST_UPDATE;
            end
          end
          ST_UPDATE: begin
            state_q <= ST_TERMINATE;
          end
          ST_TERMINATE: begin
            if (allrdy) begin
              done_o      <= 1'b1;
              evt_o       <= 1'b1;
              busy_o      <= 1'b0;
              eng_clear_o <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // One address generator per stream: sources first, then sinks
  for (genvar s = 0; s < NSTR; s++) begin : g_addr
    mac_addr_iter #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_iter (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .load_i   (addr_load),
      .step_i   (addr_step),
      .base_i   (base_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH]),
      .stride_i (stride_i[s*ADDR_WIDTH +: ADDR_WIDTH]),
      .addr_o   (addr_o[s*ADDR_WIDTH +: ADDR_WIDTH])
    );
  end

endmodule

// File: tb/tb_mac_multistream_fsm.sv
// Testbench for mac_multistream_fsm: directed scenarios plus randomized
// jobs compared against a job-level model (expected address of iteration
// i is base + i*stride, one request set per iteration, one done per job).
`timescale 1ns/1ps
module tb_mac_multistream_fsm;

  localparam int unsigned NS = 3;
  localparam int unsigned NK = 1;
  localparam int unsigned LW = 16;
  localparam int unsigned IW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned WW = 16;
  localparam int unsigned NT = NS + NK;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               clear_i;
  logic               start_i;
  logic [LW-1:0]      len_i;
  logic [IW-1:0]      n_iter_i;
  logic [NS-1:0]      src_mask_i;
  logic [NT*AW-1:0]   base_addr_i;
  logic [NT*AW-1:0]   stride_i;
  logic [WW-1:0]      wdog_limit_i;
  logic [NS-1:0]      src_ready_start_i;
  logic [NK-1:0]      snk_ready_start_i;
  logic [NS-1:0]      src_req_start_o;
  logic [NK-1:0]      snk_req_start_o;
  logic [NT*AW-1:0]   addr_o;
  logic               eng_start_o;
  logic               eng_clear_o;
  logic               eng_enable_o;
  logic [LW-1:0]      eng_cnt_i;
  logic               eng_acc_valid_i;
  logic [IW-1:0]      iter_o;
  logic               busy_o;
  logic               done_o;
  logic               evt_o;
  logic               err_o;

  mac_multistream_fsm #(
    .NB_SOURCE  (NS),
    .NB_SINK    (NK),
    .LEN_WIDTH  (LW),
    .ITER_WIDTH (IW),
    .ADDR_WIDTH (AW),
    .WDOG_WIDTH (WW)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .clear_i           (clear_i),
    .start_i           (start_i),
    .len_i             (len_i),
    .n_iter_i          (n_iter_i),
    .src_mask_i        (src_mask_i),
    .base_addr_i       (base_addr_i),
    .stride_i          (stride_i),
    .wdog_limit_i      (wdog_limit_i),
    .src_ready_start_i (src_ready_start_i),
    .snk_ready_start_i (snk_ready_start_i),
    .src_req_start_o   (src_req_start_o),
    .snk_req_start_o   (snk_req_start_o),
    .addr_o            (addr_o),
    .eng_start_o       (eng_start_o),
    .eng_clear_o       (eng_clear_o),
    .eng_enable_o      (eng_enable_o),
    .eng_cnt_i         (eng_cnt_i),
    .eng_acc_valid_i   (eng_acc_valid_i),
    .iter_o            (iter_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .evt_o             (evt_o),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Job model state
  logic [AW-1:0] base_m   [NT];
  logic [AW-1:0] stride_m [NT];
  int            m_len;
  int            m_niter;
  logic [NS-1:0] m_mask;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT*AW-1:0] exp_addr(input int it);
    logic [NT*AW-1:0] v;
    for (int s = 0; s < NT; s++) v[s*AW +: AW] = base_m[s] + stride_m[s] * AW'(it);
    return v;
  endfunction

  task automatic rand_streams();
    for (int s = 0; s < NT; s++) begin
      base_m[s]   = $urandom();
      stride_m[s] = $urandom();
    end
  endtask

  task automatic launch(input int len, input int n, input logic [NS-1:0] mask, input int wl);
    m_len = len; m_niter = n; m_mask = mask;
    for (int s = 0; s < NT; s++) begin
      base_addr_i[s*AW +: AW] = base_m[s];
      stride_i[s*AW +: AW]    = stride_m[s];
    end
    len_i = LW'(len); n_iter_i = IW'(n); src_mask_i = mask; wdog_limit_i = WW'(wl);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    // Later input changes must not affect the running job
    base_addr_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
    stride_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
    len_i        = LW'($urandom());
    n_iter_i     = IW'($urandom());
    src_mask_i   = NS'($urandom());
    wdog_limit_i = WW'($urandom());
    chk("start_busy", busy_o, 1);
    chk("start_addr", addr_o, exp_addr(0));
    chk("start_iter", iter_o, 0);
    chk("start_no_req", {src_req_start_o, snk_req_start_o}, 0);
  endtask

  task automatic expect_req(input int it, input int bound, input int lat);
    int waited = 0;
    while (src_req_start_o == '0 && snk_req_start_o == '0 && waited < bound) begin
      @(negedge clk_i);
      waited++;
    end
    chk("req_seen", snk_req_start_o, 1);
    if (lat >= 0) chk("req_latency", waited, lat);
    chk("src_req", src_req_start_o, m_mask);
    chk("eng_start", eng_start_o, 1);
    chk("eng_enable", eng_enable_o, 1);
    chk("eng_clear_low", eng_clear_o, 0);
    chk("iter", iter_o, it);
    chk("addr", addr_o, exp_addr(it));
  endtask

  task automatic run_compute(input int hold, input bit poke);
    for (int c = 0; c < hold; c++) begin
      // Near misses: valid with wrong count, right count without valid
      eng_cnt_i       = (c % 2 == 0) ? LW'(m_len + 1) : LW'(m_len);
      eng_acc_valid_i = (c % 2 == 0);
      start_i         = poke && (c == 0);
      @(negedge clk_i);
      start_i = 1'b0;
      chk("compute_enable", eng_enable_o, 1);
      chk("compute_no_req", {src_req_start_o, snk_req_start_o}, 0);
      chk("compute_eng_start_pulse", eng_start_o, 0);
      chk("compute_no_done", done_o, 0);
    end
    eng_cnt_i = LW'(m_len); eng_acc_valid_i = 1'b1;
    @(negedge clk_i);
    eng_acc_valid_i = 1'b0; eng_cnt_i = '0;
    chk("update_enable_off", eng_enable_o, 0);
  endtask

  task automatic expect_done(input int bound);
    int waited = 0;
    while (!done_o && waited < bound) begin
      chk("term_no_req", {src_req_start_o, snk_req_start_o}, 0);
      @(negedge clk_i);
      waited++;
    end
    chk("done", done_o, 1);
    chk("evt", evt_o, 1);
    chk("err_clean", err_o, 0);
    @(negedge clk_i);
    chk("done_pulse", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_eng_clear", eng_clear_o, 1);
  endtask

  task automatic run_job(input int len, input int n, input logic [NS-1:0] mask, input bit poke);
    launch(len, n, mask, 0);
    for (int it = 0; it < n; it++) begin
      expect_req(it, 20, 1);
      run_compute($urandom_range(1, 4), poke);
    end
    expect_done(20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    len_i = '0; n_iter_i = '0; src_mask_i = '0; base_addr_i = '0; stride_i = '0;
    wdog_limit_i = '0; src_ready_start_i = '1; snk_ready_start_i = '1;
    eng_cnt_i = '0; eng_acc_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_eng_clear", eng_clear_o, 1);
    chk("rst_eng_enable", eng_enable_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_iter", iter_o, 0);
    chk("rst_req", {src_req_start_o, snk_req_start_o, eng_start_o}, 0);
    chk("rst_pulses", {done_o, evt_o, err_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single iteration, all streams used
    rand_streams();
    run_job(4, 1, 3'b111, 1'b0);

    // Three iterations with a known stride on stream a
    rand_streams();
    base_m[0] = 32'h100; stride_m[0] = 32'h10;
    run_job(2, 3, 3'b111, 1'b0);

    // Unused source held not-ready must not block and must not be started
    rand_streams();
    src_ready_start_i = 3'b011;
    run_job(3, 2, 3'b011, 1'b0);
    src_ready_start_i = '1;

    // Sink not ready for five cycles after start
    rand_streams();
    snk_ready_start_i = 1'b0;
    launch(2, 1, 3'b111, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("wait_enable", eng_enable_o, 0);
      chk("wait_busy", busy_o, 1);
      chk("wait_no_req", {src_req_start_o, snk_req_start_o}, 0);
    end
    snk_ready_start_i = 1'b1;
    expect_req(0, 20, 1);
    run_compute(1, 1'b0);
    expect_done(20);

    // Soft clear in the middle of a computation
    rand_streams();
    launch(4, 3, 3'b111, 0);
    expect_req(0, 20, 1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clr_busy", busy_o, 0);
    chk("clr_iter", iter_o, 0);
    chk("clr_addr", addr_o, 0);
    chk("clr_eng_clear", eng_clear_o, 1);
    chk("clr_eng_enable", eng_enable_o, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      chk("clr_no_done", done_o, 0);
      chk("clr_no_req", {src_req_start_o, snk_req_start_o}, 0);
    end

    // Empty jobs: no stream is started, done still reported
    rand_streams();
    launch(4, 0, 3'b111, 0);
    expect_done(5);
    rand_streams();
    snk_ready_start_i = 1'b0;
    launch(0, 2, 3'b101, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("term_stall_no_done", done_o, 0);
      chk("term_stall_busy", busy_o, 1);
    end
    snk_ready_start_i = 1'b1;
    expect_done(5);

    // Engine never produces a valid accumulator with a limit of 8
    rand_streams();
    launch(4, 1, 3'b111, 8);
    expect_req(0, 20, 1);
`ifdef MAC_FSM_WATCHDOG_EN
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      if (c < 8) begin
        chk("wdog_quiet", err_o, 0);
        chk("wdog_no_done", done_o, 0);
      end else begin
        chk("wdog_err", err_o, 1);
        chk("wdog_done", done_o, 1);
        chk("wdog_evt", evt_o, 1);
      end
    end
    @(negedge clk_i);
    chk("wdog_err_pulse", err_o, 0);
    chk("wdog_idle", busy_o, 0);
    chk("wdog_no_req", {src_req_start_o, snk_req_start_o}, 0);
`else
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      chk("nowdog_err", err_o, 0);
      chk("nowdog_no_done", done_o, 0);
      chk("nowdog_enable", eng_enable_o, 1);
    end
    run_compute(1, 1'b0);
    expect_done(20);
`endif

    // Randomized jobs with a stray start pulse while busy
    for (int j = 0; j < 6; j++) begin
      rand_streams();
      run_job($urandom_range(1, 8), $urandom_range(1, 4), NS'($urandom_range(0, 7)), 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
